uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing one UART byte transmitter among 4 requesters.
//  Sits between the byte sources (status, debug, data-path, host echo) and the UART TX core.
//  Grants one byte at a time, pulses the transmitter's send_en, tracks its done level,
//  and inserts an optional idle gap between bytes.
// PARAMETERS
//  GAP_CYCLES     16   idle clk cycles after tx_done returns high before next grant (0 = none)
//  START_TIMEOUT  8    cycles allowed for tx_done to fall after send_en before error
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   4   per-source byte request; held until matching req_ack
//  req_data     in   32  source i byte at [8*i+7:8*i]; stable while req_valid[i]=1
//  req_ack      out  4   one-hot 1-cycle pulse: byte of source i accepted
//  send_en      out  1   1-cycle start pulse to UART TX core
//  tx_data      out  8   byte to UART TX core; valid with send_en, held afterwards
//  tx_done      in   1   UART TX core idle level (1 = idle/finished)
//  grant_id     out  2   index of source currently/last granted
//  busy         out  1   1 whenever FSM is not in IDLE
//  err_nostart  out  1   1-cycle pulse: tx_done did not fall within START_TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer last=3 (source 0 highest priority first); counters 0.
//  All outputs registered. States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
//  IDLE: if tx_done=1 and |req_valid: pick first set bit in order last+1,last+2,last+3,last (mod 4);
//   next cycle: send_en=1, tx_data=req_data[g], req_ack[g]=1, grant_id=g, last=g, -> WAIT_BUSY.
//   If tx_done=0 in IDLE, no grant is made (core busy from elsewhere); wait.
//  WAIT_BUSY: send_en/req_ack return to 0. tx_done=1 is expected for first cycles (core
//   latches then leaves idle). On tx_done=0 -> WAIT_DONE. After START_TIMEOUT cycles in
//   WAIT_BUSY with tx_done still 1: err_nostart pulse, -> IDLE (byte dropped, ack already given).
//  WAIT_DONE: on tx_done=1 -> GAP with gap counter cleared (GAP_CYCLES=0: directly IDLE).
//  GAP: count GAP_CYCLES cycles, then -> IDLE. Requests arriving meanwhile are held, not lost.
//  Grant-to-send_en latency: 1 cycle. Back-to-back (GAP_CYCLES=0): next send_en earliest
//   2 cycles after tx_done rises (IDLE evaluate + issue).
//  tx_data holds last byte until next grant. grant_id holds last g.
//  req_valid dropped before ack: simply not granted; no state kept per source.
//  Simultaneous requests: strict round-robin; a source never waits more than 3 grants.
//  Counters widths: gap $clog2(GAP_CYCLES+1), timeout $clog2(START_TIMEOUT+1); saturate, no wrap.
//  Reset mid-frame: FSM to IDLE immediately, outputs 0; any in-flight byte is the core's concern.
// TESTING
//  1 Only req_valid=4'b0100, data 8'hA5, tx_done model idle->busy 2 cyc after send_en ->
//    send_en 1 cycle, tx_data=A5, req_ack=0100, grant_id=2, busy until gap end.
//  2 req_valid=1111 held, 8 bytes -> grant order 0,1,2,3,0,1,2,3; exactly one ack per byte.
//  3 GAP_CYCLES=16: measure tx_done rise -> next send_en = 18 cycles; GAP_CYCLES=0 -> 2 cycles.
//  4 tx_done stuck at 1 after send_en -> err_nostart pulse after 8 cycles, FSM IDLE, next grant proceeds.
//  5 tx_done=0 at request time (core busy) -> no send_en until tx_done=1, then grant.
//  6 Assert reset during WAIT_DONE -> all outputs 0 same cycle, first later grant goes to source 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte sources / UART TX core and the round-robin arbiter.
// The arbiter connects through the slave modport; whoever drives the
// requests and models the TX core uses the master modport.
interface uart_tx_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        send_en;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_nostart;

    modport slave (
        input  req_valid, req_data, tx_done,
        output req_ack, send_en, tx_data, grant_id, busy, err_nostart
    );

    modport master (
        output req_valid, req_data, tx_done,
        input  req_ack, send_en, tx_data, grant_id, busy, err_nostart
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among 4 sources.
// Grants one byte at a time, pulses send_en, follows the core's tx_done level
// through start/finish, flags a core that never starts, and optionally
// inserts an idle gap before the next grant. All outputs are registered.
module uart_tx_arbiter #(
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 8
) (
    input logic             clk,
    input logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int NUM_SRC = 4;
    localparam int GW = (GAP_CYCLES > 0)    ? $clog2(GAP_CYCLES + 1)    : 1;
    localparam int TW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 last_q, last_d;
    logic [GW-1:0]              gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]              to_cnt_q, to_cnt_d;
    logic                       send_en_q, send_en_d;
    logic [NUM_SRC-1:0]         req_ack_q, req_ack_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic [1:0]                 grant_q, grant_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;

    logic [NUM_SRC-1:0][7:0]    req_bytes;
    logic                       pick_vld;
    logic [1:0]                 pick_id;

    assign req_bytes = bus.req_data;

    // Round-robin pick: first requester after the last granted one, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = last_q;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!pick_vld && bus.req_valid[last_q + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_id  = last_q + 2'(k);
            end
        end
    end

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        send_en_d = 1'b0;
        req_ack_d = '0;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A low tx_done here means the core is busy for someone else.
                if (bus.tx_done && pick_vld) begin
                    send_en_d          = 1'b1;
                    tx_data_d          = req_bytes[pick_id];
                    req_ack_d[pick_id] = 1'b1;
                    grant_d            = pick_id;
                    last_d             = pick_id;
                    to_cnt_d           = '0;
                    state_d            = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Core stays idle for a cycle or two while it latches the byte.
                if (!bus.tx_done) begin
                    state_d = WAIT_DONE;
                end else if (int'(to_cnt_q) + 1 >= START_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (int'(gap_cnt_q) + 1 >= GAP_CYCLES) begin
                    state_d = IDLE;
                end else if (gap_cnt_q != '1) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, round-robin pointer, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
            send_en_q <= 1'b0;
            req_ack_q <= '0;
            tx_data_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
            send_en_q <= send_en_d;
            req_ack_q <= req_ack_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bus.send_en     = send_en_q;
    assign bus.req_ack     = req_ack_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = busy_q;
    assign bus.err_nostart = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one DUT with a 16-cycle gap and one
// with no gap. Stimulus and core-model drives happen on the falling edge,
// outputs are sampled there too.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_arbiter_if ifa ();
    uart_tx_arbiter_if ifb ();

    uart_tx_arbiter #(.GAP_CYCLES(16), .START_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    uart_tx_arbiter #(.GAP_CYCLES(0), .START_TIMEOUT(8)) dut0 (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int checks = 0;
    int errors = 0;
    int acks_a = 0;

    // Tally ack pulses on the gapped DUT.
    always @(negedge clk) if (reset === 1'b1 && ifa.req_ack != 4'b0) acks_a++;

    task automatic do_reset();
        reset = 1'b0;
        ifa.req_valid = '0; ifb.req_valid = '0;
        ifa.tx_done = 1'b1; ifb.tx_done = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_send_a(input int budget, output int n);
        n = 0;
        while (ifa.send_en !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_send_b(input int budget, output int n);
        n = 0;
        while (ifb.send_en !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // TX core model: leaves idle 2 cycles after send_en, busy for lo cycles.
    task automatic core_a(input int lo);
        repeat (2) @(negedge clk);
        ifa.tx_done = 1'b0;
        repeat (lo) @(negedge clk);
        ifa.tx_done = 1'b1;
    endtask

    task automatic core_b(input int lo);
        repeat (2) @(negedge clk);
        ifb.tx_done = 1'b0;
        repeat (lo) @(negedge clk);
        ifb.tx_done = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifa.req_valid = '0; ifb.req_valid = '0;
        ifa.req_data = '0;  ifb.req_data = '0;
        ifa.tx_done = 1'b1; ifb.tx_done = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifa.send_en, ifa.req_ack, ifa.tx_data, ifa.grant_id, ifa.busy, ifa.err_nostart} !== 17'h0) begin
            errors++;
            $display("FAIL reset_a outputs got %h exp 0",
                     {ifa.send_en, ifa.req_ack, ifa.tx_data, ifa.grant_id, ifa.busy, ifa.err_nostart});
        end
        checks++;
        if ({ifb.send_en, ifb.req_ack, ifb.tx_data, ifb.grant_id, ifb.busy, ifb.err_nostart} !== 17'h0) begin
            errors++;
            $display("FAIL reset_b outputs got %h exp 0",
                     {ifb.send_en, ifb.req_ack, ifb.tx_data, ifb.grant_id, ifb.busy, ifb.err_nostart});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        do_reset();
        ifa.req_data  = 32'h00A5_0000;
        ifa.req_valid = 4'b0100;
        wait_send_a(10, n);
        checks++;
        if (ifa.send_en !== 1'b1) begin errors++; $display("FAIL t1_send got %b exp 1", ifa.send_en); end
        checks++;
        if (ifa.tx_data !== 8'hA5) begin errors++; $display("FAIL t1_txdata got %h exp a5", ifa.tx_data); end
        checks++;
        if (ifa.req_ack !== 4'b0100) begin errors++; $display("FAIL t1_ack got %b exp 0100", ifa.req_ack); end
        checks++;
        if (ifa.grant_id !== 2'd2) begin errors++; $display("FAIL t1_grant got %0d exp 2", ifa.grant_id); end
        checks++;
        if (ifa.busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b exp 1", ifa.busy); end
        ifa.req_valid = '0;
        @(negedge clk);
        checks++;
        if ({ifa.send_en, ifa.req_ack} !== 5'b0) begin
            errors++; $display("FAIL t1_pulse_width got %b exp 00000", {ifa.send_en, ifa.req_ack});
        end
        @(negedge clk);
        ifa.tx_done = 1'b0;
        repeat (4) @(negedge clk);
        ifa.tx_done = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b1) begin errors++; $display("FAIL t1_busy_gap got %b exp 1", ifa.busy); end
        @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end got %b exp 0", ifa.busy); end
        checks++;
        if ({ifa.tx_data, ifa.grant_id} !== {8'hA5, 2'd2}) begin
            errors++; $display("FAIL t1_hold got %h exp %h", {ifa.tx_data, ifa.grant_id}, {8'hA5, 2'd2});
        end
    endtask

    task automatic test_round_robin();
        int n;
        int a0;
        int         exp_g[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [3:0] exp_ack[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] exp_b[4]   = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        a0 = acks_a;
        ifa.req_data  = 32'h4433_2211;
        ifa.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            wait_send_a(40, n);
            checks++;
            if (ifa.send_en !== 1'b1) begin errors++; $display("FAIL t2_send[%0d] got %b exp 1", i, ifa.send_en); end
            checks++;
            if (ifa.grant_id !== 2'(exp_g[i])) begin
                errors++; $display("FAIL t2_grant[%0d] got %0d exp %0d", i, ifa.grant_id, exp_g[i]);
            end
            checks++;
            if (ifa.req_ack !== exp_ack[exp_g[i]]) begin
                errors++; $display("FAIL t2_ack[%0d] got %b exp %b", i, ifa.req_ack, exp_ack[exp_g[i]]);
            end
            checks++;
            if (ifa.tx_data !== exp_b[exp_g[i]]) begin
                errors++; $display("FAIL t2_data[%0d] got %h exp %h", i, ifa.tx_data, exp_b[exp_g[i]]);
            end
            core_a(3);
        end
        ifa.req_valid = '0;
        checks++;
        if (acks_a - a0 != 8) begin errors++; $display("FAIL t2_ack_count got %0d exp 8", acks_a - a0); end
    endtask

    task automatic test_gap_latency();
        int n;
        do_reset();
        ifa.req_data  = 32'h7E00_0000;
        ifa.req_valid = 4'b1000;
        wait_send_a(10, n);
        core_a(4);
        wait_send_a(40, n);
        checks++;
        if (n != 18 || ifa.send_en !== 1'b1) begin
            errors++; $display("FAIL t3_gap16_latency got %0d exp 18", n);
        end
        ifa.req_valid = '0;
        core_a(4);

        ifb.req_data  = 32'h0000_003C;
        ifb.req_valid = 4'b0001;
        wait_send_b(10, n);
        checks++;
        if ({ifb.send_en, ifb.grant_id, ifb.tx_data} !== {1'b1, 2'd0, 8'h3C}) begin
            errors++; $display("FAIL t3_b_first got %h exp %h", {ifb.send_en, ifb.grant_id, ifb.tx_data}, {1'b1, 2'd0, 8'h3C});
        end
        core_b(3);
        wait_send_b(10, n);
        checks++;
        if (n != 2 || ifb.send_en !== 1'b1) begin
            errors++; $display("FAIL t3_gap0_latency got %0d exp 2", n);
        end
        ifb.req_valid = '0;
        core_b(3);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        ifa.req_data  = 32'hD700_5C00;
        ifa.req_valid = 4'b0010;
        wait_send_a(10, n);
        checks++;
        if ({ifa.send_en, ifa.grant_id} !== {1'b1, 2'd1}) begin
            errors++; $display("FAIL t4_grant got %b exp 101", {ifa.send_en, ifa.grant_id});
        end
        ifa.req_valid = 4'b1000;
        n = 0;
        while (ifa.err_nostart !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL t4_err_latency got %0d exp 8", n); end
        checks++;
        if (ifa.busy !== 1'b0) begin errors++; $display("FAIL t4_idle got busy=%b exp 0", ifa.busy); end
        @(negedge clk);
        checks++;
        if (ifa.err_nostart !== 1'b0) begin errors++; $display("FAIL t4_err_pulse got %b exp 0", ifa.err_nostart); end
        checks++;
        if ({ifa.send_en, ifa.grant_id, ifa.tx_data} !== {1'b1, 2'd3, 8'hD7}) begin
            errors++; $display("FAIL t4_next_grant got %h exp %h", {ifa.send_en, ifa.grant_id, ifa.tx_data}, {1'b1, 2'd3, 8'hD7});
        end
        ifa.req_valid = '0;
        core_a(3);
    endtask

    task automatic test_core_busy();
        int n;
        int sends;
        do_reset();
        ifa.tx_done   = 1'b0;
        ifa.req_data  = 32'h0000_0096;
        ifa.req_valid = 4'b0001;
        sends = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.send_en !== 1'b0 || ifa.busy !== 1'b0) sends++;
        end
        checks++;
        if (sends != 0) begin errors++; $display("FAIL t5_no_grant got %0d active cycles exp 0", sends); end
        ifa.tx_done = 1'b1;
        wait_send_a(10, n);
        checks++;
        if (n != 1 || ifa.grant_id !== 2'd0 || ifa.tx_data !== 8'h96) begin
            errors++; $display("FAIL t5_grant got n=%0d id=%0d data=%h exp n=1 id=0 data=96", n, ifa.grant_id, ifa.tx_data);
        end
        ifa.req_valid = '0;
        core_a(3);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        ifa.req_data  = 32'h00E1_0000;
        ifa.req_valid = 4'b0100;
        wait_send_a(10, n);
        ifa.req_valid = '0;
        repeat (2) @(negedge clk);
        ifa.tx_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ifa.busy, ifa.grant_id, ifa.tx_data} !== {1'b1, 2'd2, 8'hE1}) begin
            errors++; $display("FAIL t6_pre got %h exp %h", {ifa.busy, ifa.grant_id, ifa.tx_data}, {1'b1, 2'd2, 8'hE1});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({ifa.send_en, ifa.req_ack, ifa.tx_data, ifa.grant_id, ifa.busy, ifa.err_nostart} !== 17'h0) begin
            errors++;
            $display("FAIL t6_async_clear got %h exp 0",
                     {ifa.send_en, ifa.req_ack, ifa.tx_data, ifa.grant_id, ifa.busy, ifa.err_nostart});
        end
        @(negedge clk);
        reset = 1'b1;
        ifa.tx_done   = 1'b1;
        ifa.req_data  = 32'h4433_2211;
        ifa.req_valid = 4'b1111;
        wait_send_a(10, n);
        checks++;
        if ({ifa.send_en, ifa.grant_id, ifa.tx_data} !== {1'b1, 2'd0, 8'h11}) begin
            errors++; $display("FAIL t6_first_grant got %h exp %h", {ifa.send_en, ifa.grant_id, ifa.tx_data}, {1'b1, 2'd0, 8'h11});
        end
        ifa.req_valid = '0;
        core_a(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gap_latency();
        test_timeout();
        test_core_busy();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
